ysyx_22040895_div: RTL and testbench

- Iterative radix-2 restoring divider for the RV64M divide/remainder instructions: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits in EX beside the ALU. EX stalls the pipeline while the divider is busy.
- Upstream uses a valid/ready handshake on the request side and on the result side.
- Produces one quotient bit per cycle.

---
 rtl/ysyx_22040895_div_pkg.sv | 20 ++
 rtl/ysyx_22040895_div_step.sv | 25 ++
 rtl/ysyx_22040895_div.sv | 174 +++++++++++++++++
 tb/tb_ysyx_22040895_div.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_div_pkg.sv
// Shared types and widths for the ysyx_22040895 iterative divider.
package ysyx_22040895_div_pkg;

  localparam int REG_BUS_W = 64;
  localparam int DIV_CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } divop_e;

endpackage

// File: rtl/ysyx_22040895_div_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract, restore on borrow.
module ysyx_22040895_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The shifted remainder can need XLEN+1 bits, so the trial runs one bit wider.
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    trial   = shifted - {1'b0, div_i};
    q_bit_o = ~trial[XLEN];
    rem_o   = q_bit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    quot_o  = {quot_i[XLEN-2:0], q_bit_o};
  end

endmodule

// File: rtl/ysyx_22040895_div.sv
// RV64M radix-2 restoring divider (DIV/DIVU/REM/REMU and W forms), one quotient bit per cycle.
// Optional build macro YSYX_22040895_DIV_FASTPATH_EN: finish in one cycle when |divisor| > |dividend|.
module ysyx_22040895_div
  import ysyx_22040895_div_pkg::*;
#(
  parameter int XLEN  = REG_BUS_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i_div,
  output logic            ready_o_div,
  input  logic [1:0]      divop_i_div,
  input  logic            wordop_i_div,
  input  logic [XLEN-1:0] dividend_i_div,
  input  logic [XLEN-1:0] divisor_i_div,
  input  logic            flush_i_div,
  output logic            valid_o_div,
  input  logic            ready_i_div,
  output logic [XLEN-1:0] result_o_div,
  output logic            busy_o_div
);

  function automatic logic [XLEN-1:0] pick_result(input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r,
                                                  input logic            sel_rem,
                                                  input logic            word);
    logic [XLEN-1:0] v;
    v = sel_rem ? r : q;
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            sel_rem_q, sel_rem_d;
  logic            word_q, word_d;

  logic            is_signed;
  logic [XLEN-1:0] a_prep, b_prep, a_mag, b_mag, min_val;
  logic            a_neg, b_neg, div_zero, overflow, fast_hit;
  logic [XLEN-1:0] step_rem, step_quot;
  logic            step_bit;
  logic            unused_step_bit;

  assign unused_step_bit = step_bit;

  // Operand preparation: word truncation and extension, then magnitudes for signed ops.
  always_comb begin
    is_signed = ~divop_i_div[0];
    if (wordop_i_div) begin
      a_prep = {{(XLEN-32){is_signed & dividend_i_div[31]}}, dividend_i_div[31:0]};
      b_prep = {{(XLEN-32){is_signed & divisor_i_div[31]}}, divisor_i_div[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_prep = dividend_i_div;
      b_prep = divisor_i_div;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_prep[XLEN-1];
    b_neg    = is_signed & b_prep[XLEN-1];
    a_mag    = a_neg ? -a_prep : a_prep;
    b_mag    = b_neg ? -b_prep : b_prep;
    div_zero = (b_prep == '0);
    overflow = is_signed && (a_prep == min_val) && (b_prep == '1);
`ifdef YSYX_22040895_DIV_FASTPATH_EN
    fast_hit = !div_zero && (b_mag > a_mag);
`else
    fast_hit = 1'b0;
`endif
  end

  ysyx_22040895_div_step #(.XLEN(XLEN)) u_step (
    .rem_i   (rem_q),
    .quot_i  (quot_q),
    .div_i   (dsr_q),
    .rem_o   (step_rem),
    .quot_o  (step_quot),
    .q_bit_o (step_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dsr_d     = dsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    sel_rem_d = sel_rem_q;
    word_d    = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i_div && !flush_i_div) begin
          q_neg_d   = a_neg ^ b_neg;
          r_neg_d   = a_neg;
          sel_rem_d = divop_i_div[1];
          word_d    = wordop_i_div;
          if (div_zero) begin
            state_d  = ST_DONE;
            result_d = pick_result('1, a_prep, divop_i_div[1], wordop_i_div);
          end else if (overflow) begin
            state_d  = ST_DONE;
            result_d = pick_result(a_prep, '0, divop_i_div[1], wordop_i_div);
          end else if (fast_hit) begin
            state_d  = ST_DONE;
            result_d = pick_result('0, a_prep, divop_i_div[1], wordop_i_div);
          end else begin
            state_d = ST_CALC;
            cnt_d   = wordop_i_div ? CNT_W'(32) : CNT_W'(XLEN);
            rem_d   = '0;
            // Word dividends sit in the upper half so 32 shifts consume exactly them.
            quot_d  = wordop_i_div ? (a_mag << 32) : a_mag;
            dsr_d   = b_mag;
          end
        end
      end
      ST_CALC: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = pick_result(q_neg_q ? -step_quot : step_quot,
                                 r_neg_q ? -step_rem : step_rem,
                                 sel_rem_q, word_q);
        end
      end
      ST_DONE: begin
        if (ready_i_div) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i_div) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers are only meaningful once loaded by an accepted request.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quot_q    <= quot_d;
    dsr_q     <= dsr_d;
    q_neg_q   <= q_neg_d;
    r_neg_q   <= r_neg_d;
    sel_rem_q <= sel_rem_d;
    word_q    <= word_d;
  end

  assign ready_o_div  = (state_q == ST_IDLE);
  assign valid_o_div  = (state_q == ST_DONE);
  assign busy_o_div   = (state_q != ST_IDLE);
  assign result_o_div = result_q;

endmodule

// File: tb/tb_ysyx_22040895_div.sv
// Directed bench for ysyx_22040895_div: latency, results, stall, flush and reset.
module tb_ysyx_22040895_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i_div;
  logic        ready_o_div;
  logic [1:0]  divop_i_div;
  logic        wordop_i_div;
  logic [63:0] dividend_i_div;
  logic [63:0] divisor_i_div;
  logic        flush_i_div;
  logic        valid_o_div;
  logic        ready_i_div;
  logic [63:0] result_o_div;
  logic        busy_o_div;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
`ifdef YSYX_22040895_DIV_FASTPATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 65;
`endif

  always #5 clk = ~clk;

  ysyx_22040895_div dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i_div    (valid_i_div),
    .ready_o_div    (ready_o_div),
    .divop_i_div    (divop_i_div),
    .wordop_i_div   (wordop_i_div),
    .dividend_i_div (dividend_i_div),
    .divisor_i_div  (divisor_i_div),
    .flush_i_div    (flush_i_div),
    .valid_o_div    (valid_o_div),
    .ready_i_div    (ready_i_div),
    .result_o_div   (result_o_div),
    .busy_o_div     (busy_o_div)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request; returns the cycle valid_o_div first rose (accept edge = 0) and the result.
  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic hold,
                        output int lat, output logic [63:0] res);
    @(negedge clk);
    divop_i_div    = op;
    wordop_i_div   = word;
    dividend_i_div = a;
    divisor_i_div  = b;
    ready_i_div    = !hold;
    valid_i_div    = 1'b1;
    @(posedge clk);
    #1;
    valid_i_div    = 1'b0;
    dividend_i_div = '1;
    divisor_i_div  = 64'd5;
    lat = 1;
    while (!valid_o_div && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result_o_div;
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
    int lat;
    logic [63:0] res;
    run_op(op, word, a, b, 1'b0, lat, res);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk(tag, res, exp);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, ready_o_div, valid_o_div}, 64'd2);
  endtask

  initial begin
    int lat;
    int rises;
    logic [63:0] res;
    rst_n          = 1'b0;
    valid_i_div    = 1'b0;
    divop_i_div    = DIV;
    wordop_i_div   = 1'b0;
    dividend_i_div = '0;
    divisor_i_div  = '0;
    flush_i_div    = 1'b0;
    ready_i_div    = 1'b1;
    #12;
    chk("rst_ready", {63'd0, ready_o_div}, 64'd1);
    chk("rst_valid", {63'd0, valid_o_div}, 64'd0);
    chk("rst_busy",  {63'd0, busy_o_div},  64'd0);
    chk("rst_result", result_o_div, 64'd0);
    rst_n = 1'b1;

    op_check("divu_100_7",  DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    op_check("remu_100_7",  REMU, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    op_check("div_m7_2",    DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    op_check("rem_m7_2",    REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    op_check("divw_ovf",    DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1);
    op_check("remw_ovf",    REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'd0, 1);
    op_check("div_ovf64",   DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1);
    op_check("divu_by0",    DIVU, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    op_check("remu_by0",    REMU, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    op_check("divuw_5_3",   DIVU, 1'b1, 64'h1_0000_0005, 64'd3, 64'd1, 33);
    op_check("divuw_sext",  DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,
             64'hFFFF_FFFF_FFFF_FFFF, 33);
    op_check("remw_m7_2",   REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFF, 33);
    op_check("div_5_m9",    DIV,  1'b0, 64'd5, -64'sd9, 64'd0, FAST_LAT);
    op_check("rem_m5_9",    REM,  1'b0, -64'sd5, 64'd9, 64'hFFFF_FFFF_FFFF_FFFB, FAST_LAT);

    // Result stall: consumer holds off for 10 cycles.
    run_op(DIVU, 1'b0, 64'd1000, 64'd10, 1'b1, lat, res);
    chk("hold_lat", 64'(lat), 64'd65);
    chk("hold_res", res, 64'd100);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_state", {61'd0, valid_o_div, ready_o_div, busy_o_div}, 64'b101);
      chk("hold_stable", result_o_div, 64'd100);
    end
    ready_i_div = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", {62'd0, ready_o_div, valid_o_div}, 64'd2);

    // Flush in cycle 20 of a 64-bit DIV.
    @(negedge clk);
    divop_i_div    = DIV;
    wordop_i_div   = 1'b0;
    dividend_i_div = 64'd999;
    divisor_i_div  = 64'd3;
    valid_i_div    = 1'b1;
    @(posedge clk);
    #1;
    valid_i_div = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
    end
    flush_i_div = 1'b1;
    @(posedge clk);
    #1;
    flush_i_div = 1'b0;
    chk("flush_ready", {61'd0, ready_o_div, valid_o_div, busy_o_div}, 64'b100);
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (valid_o_div) rises++;
    end
    chk("flush_no_valid", 64'(rises), 64'd0);
    op_check("after_flush", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    divop_i_div    = DIVU;
    wordop_i_div   = 1'b0;
    dividend_i_div = 64'd77;
    divisor_i_div  = 64'd7;
    valid_i_div    = 1'b1;
    @(posedge clk);
    #1;
    valid_i_div = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", {63'd0, busy_o_div}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {61'd0, ready_o_div, valid_o_div, busy_o_div}, 64'b100);
    chk("mid_rst_result", result_o_div, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (valid_o_div) rises++;
    end
    chk("rst_no_valid", 64'(rises), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
